// File: rtl/fifo_reader_thread.sv
// rtl/fifo_reader_thread.sv - run-based FIFO reader that pops WORDS words and returns their sum
//
// Each run starts when run_req is seen in IDLE. The block then alternates POP (issue one pop
// strobe when the FIFO is not empty) and CAPT (accumulate the word returned one clock later)
// until WORDS words have been summed. The sum is published on return_b when the run ends.
//
// Ports:
//   clock       in   single clock, all state updates on posedge
//   reset       in   asynchronous active-high reset
//   ce          in   clock enable; when low every register holds
//   run_req     in   level start request from the initiator
//   run_busy    out  high while a run is in progress
//   fifo_empty  in   read-side empty flag of the upstream FIFO
//   fifo_rd_en  out  one-cycle pop strobe (combinational from state and inputs)
//   fifo_rdata  in   FIFO read data, valid one clock after fifo_rd_en
//   return_b    out  sum (mod 2^DATA_W) of the words of the last completed run
//   run_err     out  timeout abort flag (only with FIFO_READER_TIMEOUT_EN)
//
// Optional feature macro: FIFO_READER_TIMEOUT_EN
//   Adds the TIMEOUT parameter, the run_err port and a counter that aborts a run after
//   TIMEOUT consecutive ce-qualified cycles stuck in POP on an empty FIFO.
module fifo_reader_thread #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned WORDS   = 16
`ifdef FIFO_READER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 64
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ce,
  input  logic              run_req,
  output logic              run_busy,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rdata,
`ifdef FIFO_READER_TIMEOUT_EN
  output logic              run_err,
`endif
  output logic [DATA_W-1:0] return_b
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_POP  = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // WORDS is limited to 1..65535, so a 16-bit word counter always suffices.
  localparam logic [15:0] LAST_CNT = 16'(WORDS - 1);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] acc_q,   acc_d;
  logic [15:0]       cnt_q,   cnt_d;
  logic [DATA_W-1:0] ret_q,   ret_d;
  logic              busy_q,  busy_d;
  logic [DATA_W-1:0] sum;

`ifdef FIFO_READER_TIMEOUT_EN
  localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  // Carry out of the top bit is intentionally dropped.
  assign sum = acc_q + fifo_rdata;

  // The pop is gated by ce so a frozen cycle never consumes a FIFO word.
  assign fifo_rd_en = (state_q == ST_POP) && ce && !fifo_empty;
  assign run_busy   = busy_q;
  assign return_b   = ret_q;
`ifdef FIFO_READER_TIMEOUT_EN
  assign run_err    = err_q;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ret_d   = ret_q;
    busy_d  = busy_q;
`ifdef FIFO_READER_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    if (ce) begin
      case (state_q)
        ST_IDLE: begin
          if (run_req) begin
            state_d = ST_POP;
            busy_d  = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
`ifdef FIFO_READER_TIMEOUT_EN
            tmo_d   = '0;
            err_d   = 1'b0;
`endif
          end
        end
        ST_POP: begin
          if (!fifo_empty) begin
            state_d = ST_CAPT;
`ifdef FIFO_READER_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end
`ifdef FIFO_READER_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            // Abort: leave return_b untouched so the previous result stays visible.
            state_d = ST_DONE;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            tmo_d   = '0;
          end else begin
            tmo_d   = tmo_q + 1'b1;
          end
`endif
        end
        ST_CAPT: begin
          acc_d = sum;
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == LAST_CNT) begin
            // Publish directly from the adder so return_b and busy change on the same edge.
            state_d = ST_DONE;
            ret_d   = sum;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_POP;
          end
        end
        ST_DONE: begin
          // Requires run_req to drop before another run can begin.
          if (!run_req) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ret_q   <= '0;
      busy_q  <= 1'b0;
`ifdef FIFO_READER_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ret_q   <= ret_d;
      busy_q  <= busy_d;
`ifdef FIFO_READER_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule
